// File: rtl/id_ex_stage.sv
// id_ex_stage
// -----------
// Decode stage of the MIPS pipeline together with the ID/EX pipeline register.
// The instruction held in IF/ID is decoded combinationally. Its source register
// numbers go straight out to the register file. The register file reads on the
// falling edge, so the returned operands are stable at the next rising edge,
// where they are captured into the ID/EX register together with the control bits.
//
// Ports
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   if_id_valid/instr/pc4         contents of the IF/ID register
//   rd_data1, rd_data2            register-file ReadData1 / ReadData2
//   wb_regwrite, wb_rd, wb_data   write-back port; bypassed into the captured operands
//   flush                         taken branch from EX; the ID instruction is killed
//   rs_addr, rt_addr              combinational register-file read addresses
//   stall                         combinational load-use stall (hold PC and IF/ID)
//   ex_*                          registered operands and control handed to EX

module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_id_valid,
    input  logic [31:0]       if_id_instr,
    input  logic [DATA_W-1:0] if_id_pc4,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic [REG_AW-1:0] rs_addr,
    output logic [REG_AW-1:0] rt_addr,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_dest,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_alusrc,
    output logic              ex_branch
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Instruction fields
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rd_field;
    logic [15:0]       imm16;

    // Decoded control for the instruction currently in IF/ID
    logic              dec_regwrite;
    logic              dec_memread;
    logic              dec_memwrite;
    logic              dec_memtoreg;
    logic              dec_alusrc;
    logic              dec_branch;
    logic              dec_uses_rt;
    logic [REG_AW-1:0] dec_dest;
    logic [DATA_W-1:0] dec_imm;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              load_use;
    logic              bubble;

    // ID/EX register
    logic              ex_valid_q,    ex_valid_d;
    logic [DATA_W-1:0] ex_a_q,        ex_a_d;
    logic [DATA_W-1:0] ex_b_q,        ex_b_d;
    logic [DATA_W-1:0] ex_imm_q,      ex_imm_d;
    logic [DATA_W-1:0] ex_pc4_q,      ex_pc4_d;
    logic [REG_AW-1:0] ex_rs_q,       ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q,       ex_rt_d;
    logic [REG_AW-1:0] ex_dest_q,     ex_dest_d;
    logic [5:0]        ex_opcode_q,   ex_opcode_d;
    logic [5:0]        ex_funct_q,    ex_funct_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q,  ex_memread_d;
    logic              ex_memwrite_q, ex_memwrite_d;
    logic              ex_memtoreg_q, ex_memtoreg_d;
    logic              ex_alusrc_q,   ex_alusrc_d;
    logic              ex_branch_q,   ex_branch_d;

    assign opcode   = if_id_instr[31:26];
    assign rs_addr  = if_id_instr[25:21];
    assign rt_addr  = if_id_instr[20:16];
    assign rd_field = if_id_instr[15:11];
    assign funct    = if_id_instr[5:0];
    assign imm16    = if_id_instr[15:0];

    // Main decoder. Unknown opcodes fall through with every control bit low and
    // no destination, so they travel down the pipe as harmless no-ops. A decoded
    // destination of $0 is already the all-zero value, which is exactly the
    // "no register write" encoding EX expects, so no separate masking is needed.
    always_comb begin
        dec_regwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_memtoreg = 1'b0;
        dec_alusrc   = 1'b0;
        dec_branch   = 1'b0;
        dec_uses_rt  = 1'b0;
        dec_dest     = '0;
        case (opcode)
            OP_RTYPE: begin
                dec_regwrite = 1'b1;
                dec_uses_rt  = 1'b1;
                dec_dest     = rd_field;
            end
            OP_LW: begin
                dec_regwrite = 1'b1;
                dec_memread  = 1'b1;
                dec_memtoreg = 1'b1;
                dec_alusrc   = 1'b1;
                dec_dest     = rt_addr;
            end
            OP_SW: begin
                dec_memwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_uses_rt  = 1'b1;
            end
            OP_BEQ: begin
                dec_branch   = 1'b1;
                dec_uses_rt  = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_dest     = rt_addr;
            end
            default: begin
            end
        endcase
    end

    // Logical immediates are zero-extended; everything else is sign-extended.
    always_comb begin
        if (opcode == OP_ANDI || opcode == OP_ORI) begin
            dec_imm = {{(DATA_W-16){1'b0}}, imm16};
        end else begin
            dec_imm = {{(DATA_W-16){imm16[15]}}, imm16};
        end
    end

    // The register file is written on the same rising edge that captures its read
    // data, so the read port still shows the old value. Bypass the write-back
    // data directly; $0 is never bypassed because it is hard-wired to zero.
    always_comb begin
        op_a = rd_data1;
        op_b = rd_data2;
        if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs_addr)) begin
            op_a = wb_data;
        end
        if (wb_regwrite && (wb_rd != '0) && (wb_rd == rt_addr)) begin
            op_b = wb_data;
        end
    end

    // Load-use detection against the load sitting in EX. The rs match is not
    // qualified by usage, the rt match only counts when the instruction reads rt.
    // A flush kills the ID instruction, so there is nothing left to stall.
    always_comb begin
        load_use = if_id_valid && ex_valid_q && ex_memread_q && (ex_dest_q != '0) &&
                   ((ex_dest_q == rs_addr) || (dec_uses_rt && (ex_dest_q == rt_addr)));
        stall    = load_use && !flush;
        bubble   = flush || load_use || !if_id_valid;
    end

    // Next state of the ID/EX register. Datapath fields are always loaded; on a
    // bubble only the valid bit, control bits and destination are forced to zero,
    // which is all EX and the hazard logic look at.
    always_comb begin
        ex_a_d        = op_a;
        ex_b_d        = op_b;
        ex_imm_d      = dec_imm;
        ex_pc4_d      = if_id_pc4;
        ex_rs_d       = rs_addr;
        ex_rt_d       = rt_addr;
        ex_opcode_d   = opcode;
        ex_funct_d    = funct;
        ex_valid_d    = 1'b0;
        ex_dest_d     = '0;
        ex_regwrite_d = 1'b0;
        ex_memread_d  = 1'b0;
        ex_memwrite_d = 1'b0;
        ex_memtoreg_d = 1'b0;
        ex_alusrc_d   = 1'b0;
        ex_branch_d   = 1'b0;
        if (!bubble) begin
            ex_valid_d    = 1'b1;
            ex_dest_d     = dec_dest;
            ex_regwrite_d = dec_regwrite;
            ex_memread_d  = dec_memread;
            ex_memwrite_d = dec_memwrite;
            ex_memtoreg_d = dec_memtoreg;
            ex_alusrc_d   = dec_alusrc;
            ex_branch_d   = dec_branch;
        end
    end

    // ID/EX register with synchronous reset clearing every field.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_imm_q      <= '0;
            ex_pc4_q      <= '0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_dest_q     <= '0;
            ex_opcode_q   <= '0;
            ex_funct_q    <= '0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_memwrite_q <= 1'b0;
            ex_memtoreg_q <= 1'b0;
            ex_alusrc_q   <= 1'b0;
            ex_branch_q   <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_imm_q      <= ex_imm_d;
            ex_pc4_q      <= ex_pc4_d;
            ex_rs_q       <= ex_rs_d;
            ex_rt_q       <= ex_rt_d;
            ex_dest_q     <= ex_dest_d;
            ex_opcode_q   <= ex_opcode_d;
            ex_funct_q    <= ex_funct_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= ex_memread_d;
            ex_memwrite_q <= ex_memwrite_d;
            ex_memtoreg_q <= ex_memtoreg_d;
            ex_alusrc_q   <= ex_alusrc_d;
            ex_branch_q   <= ex_branch_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_a        = ex_a_q;
    assign ex_b        = ex_b_q;
    assign ex_imm      = ex_imm_q;
    assign ex_pc4      = ex_pc4_q;
    assign ex_rs       = ex_rs_q;
    assign ex_rt       = ex_rt_q;
    assign ex_dest     = ex_dest_q;
    assign ex_opcode   = ex_opcode_q;
    assign ex_funct    = ex_funct_q;
    assign ex_regwrite = ex_regwrite_q;
    assign ex_memread  = ex_memread_q;
    assign ex_memwrite = ex_memwrite_q;
    assign ex_memtoreg = ex_memtoreg_q;
    assign ex_alusrc   = ex_alusrc_q;
    assign ex_branch   = ex_branch_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// --------------
// Directed testbench for id_ex_stage. A tiny register-file model returns the
// register number as its contents (r2 = 2, r3 = 3, ...), so operand values can
// be worked out by hand from the instruction encodings.

module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc4;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dest;
    logic [5:0]  ex_opcode;
    logic [5:0]  ex_funct;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_memtoreg;
    logic        ex_alusrc;
    logic        ex_branch;

    int n_checks;
    int n_fail;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .stall(stall),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an instruction in IF/ID and the register-file data for its fields.
    task automatic drive_instr(input logic valid, input logic [31:0] instr, input logic [31:0] pc4);
        if_id_valid = valid;
        if_id_instr = instr;
        if_id_pc4   = pc4;
        rd_data1    = {27'd0, instr[25:21]};
        rd_data2    = {27'd0, instr[20:16]};
        #1;
    endtask

    // Advance through one rising edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_instr(1'b1, 32'h00432020, 32'h0000_0104);
        tick();
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %0h expected 0", ex_valid); end
        n_checks++; if (ex_a !== 32'h0 || ex_b !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_ops: got a=%h b=%h expected 0 0", ex_a, ex_b); end
        n_checks++; if (ex_pc4 !== 32'h0 || ex_imm !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc4_imm: got pc4=%h imm=%h expected 0 0", ex_pc4, ex_imm); end
        n_checks++; if (ex_dest !== 5'd0 || ex_regwrite !== 1'b0 || ex_funct !== 6'h0) begin n_fail++; $display("[TB] FAIL reset_ctrl: got dest=%0d rw=%0b funct=%h expected 0 0 0", ex_dest, ex_regwrite, ex_funct); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %0b expected 0", stall); end
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        // add $4,$2,$3
        drive_instr(1'b1, 32'h00432020, 32'h0000_0104);
        n_checks++; if (rs_addr !== 5'd2 || rt_addr !== 5'd3) begin n_fail++; $display("[TB] FAIL rtype_addr: got rs=%0d rt=%0d expected 2 3", rs_addr, rt_addr); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL rtype_stall: got %0b expected 0", stall); end
        tick();
        n_checks++; if (ex_a !== 32'd2 || ex_b !== 32'd3) begin n_fail++; $display("[TB] FAIL rtype_ops: got a=%h b=%h expected 2 3", ex_a, ex_b); end
        n_checks++; if (ex_dest !== 5'd4 || ex_regwrite !== 1'b1 || ex_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rtype_ctrl: got dest=%0d rw=%0b v=%0b expected 4 1 1", ex_dest, ex_regwrite, ex_valid); end
        n_checks++; if (ex_memread !== 1'b0 || ex_alusrc !== 1'b0 || ex_branch !== 1'b0 || ex_memwrite !== 1'b0) begin n_fail++; $display("[TB] FAIL rtype_ctrl0: got mr=%0b as=%0b br=%0b mw=%0b expected 0 0 0 0", ex_memread, ex_alusrc, ex_branch, ex_memwrite); end
        n_checks++; if (ex_pc4 !== 32'h104 || ex_funct !== 6'h20 || ex_opcode !== 6'h00) begin n_fail++; $display("[TB] FAIL rtype_fields: got pc4=%h funct=%h op=%h expected 104 20 00", ex_pc4, ex_funct, ex_opcode); end
        n_checks++; if (ex_rs !== 5'd2 || ex_rt !== 5'd3) begin n_fail++; $display("[TB] FAIL rtype_srcs: got rs=%0d rt=%0d expected 2 3", ex_rs, ex_rt); end
        // add $0,$2,$3 : destination $0 means no destination
        drive_instr(1'b1, 32'h00430020, 32'h0000_0108);
        tick();
        n_checks++; if (ex_dest !== 5'd0) begin n_fail++; $display("[TB] FAIL rtype_dest0: got %0d expected 0", ex_dest); end
    endtask

    task automatic test_bypass();
        // rs bypass only
        drive_instr(1'b1, 32'h00432020, 32'h0000_0104);
        wb_regwrite = 1'b1; wb_rd = 5'd2; wb_data = 32'h55;
        tick();
        n_checks++; if (ex_a !== 32'h55 || ex_b !== 32'd3) begin n_fail++; $display("[TB] FAIL bypass_rs: got a=%h b=%h expected 55 3", ex_a, ex_b); end
        // add $4,$2,$2 : both operands bypass together
        drive_instr(1'b1, 32'h00422020, 32'h0000_0104);
        tick();
        n_checks++; if (ex_a !== 32'h55 || ex_b !== 32'h55) begin n_fail++; $display("[TB] FAIL bypass_both: got a=%h b=%h expected 55 55", ex_a, ex_b); end
        // rt bypass only
        drive_instr(1'b1, 32'h00432020, 32'h0000_0104);
        wb_rd = 5'd3; wb_data = 32'hABCD_0001;
        tick();
        n_checks++; if (ex_a !== 32'd2 || ex_b !== 32'hABCD_0001) begin n_fail++; $display("[TB] FAIL bypass_rt: got a=%h b=%h expected 2 abcd0001", ex_a, ex_b); end
        // add $4,$0,$3 : $0 is never bypassed
        drive_instr(1'b1, 32'h00032020, 32'h0000_0104);
        wb_rd = 5'd0; wb_data = 32'h77;
        tick();
        n_checks++; if (ex_a !== 32'd0) begin n_fail++; $display("[TB] FAIL bypass_r0: got %h expected 0", ex_a); end
        // write enable low: no bypass
        drive_instr(1'b1, 32'h00432020, 32'h0000_0104);
        wb_regwrite = 1'b0; wb_rd = 5'd2; wb_data = 32'h99;
        tick();
        n_checks++; if (ex_a !== 32'd2) begin n_fail++; $display("[TB] FAIL bypass_norw: got %h expected 2", ex_a); end
        wb_rd = 5'd0; wb_data = 32'h0;
    endtask

    task automatic test_load_use();
        // lw $5,8($1)
        drive_instr(1'b1, 32'h8C250008, 32'h0000_0200);
        tick();
        n_checks++; if (ex_memread !== 1'b1 || ex_memtoreg !== 1'b1 || ex_alusrc !== 1'b1 || ex_regwrite !== 1'b1 || ex_dest !== 5'd5) begin n_fail++; $display("[TB] FAIL lw_ctrl: got mr=%0b m2r=%0b as=%0b rw=%0b dest=%0d expected 1 1 1 1 5", ex_memread, ex_memtoreg, ex_alusrc, ex_regwrite, ex_dest); end
        n_checks++; if (ex_imm !== 32'd8 || ex_a !== 32'd1) begin n_fail++; $display("[TB] FAIL lw_ops: got imm=%h a=%h expected 8 1", ex_imm, ex_a); end
        // add $6,$5,$2 depends on the load
        drive_instr(1'b1, 32'h00A23020, 32'h0000_0204);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL lu_stall: got %0b expected 1", stall); end
        tick();
        n_checks++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0 || ex_dest !== 5'd0) begin n_fail++; $display("[TB] FAIL lu_bubble: got v=%0b rw=%0b mr=%0b dest=%0d expected 0 0 0 0", ex_valid, ex_regwrite, ex_memread, ex_dest); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL lu_stall_once: got %0b expected 0", stall); end
        tick();
        n_checks++; if (ex_valid !== 1'b1 || ex_dest !== 5'd6 || ex_regwrite !== 1'b1) begin n_fail++; $display("[TB] FAIL lu_issue: got v=%0b dest=%0d rw=%0b expected 1 6 1", ex_valid, ex_dest, ex_regwrite); end
        // lw $5 then sw $5,0($1) : rt is a source for sw
        drive_instr(1'b1, 32'h8C250008, 32'h0000_0208);
        tick();
        drive_instr(1'b1, 32'hAC250000, 32'h0000_020C);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL lu_sw_rt: got %0b expected 1", stall); end
        tick();
    endtask

    task automatic test_no_stall();
        // lw $5 then addi $5,$6,1 : rt matches but is not a source
        drive_instr(1'b1, 32'h8C250008, 32'h0000_0300);
        tick();
        drive_instr(1'b1, 32'h20C50001, 32'h0000_0304);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL nostall_addi: got %0b expected 0", stall); end
        tick();
        n_checks++; if (ex_valid !== 1'b1 || ex_dest !== 5'd5 || ex_alusrc !== 1'b1 || ex_memread !== 1'b0) begin n_fail++; $display("[TB] FAIL addi_issue: got v=%0b dest=%0d as=%0b mr=%0b expected 1 5 1 0", ex_valid, ex_dest, ex_alusrc, ex_memread); end
        // lw $0,8($1) then add $6,$0,$2
        drive_instr(1'b1, 32'h8C200008, 32'h0000_0308);
        tick();
        n_checks++; if (ex_memread !== 1'b1 || ex_dest !== 5'd0) begin n_fail++; $display("[TB] FAIL lw_r0: got mr=%0b dest=%0d expected 1 0", ex_memread, ex_dest); end
        drive_instr(1'b1, 32'h00023020, 32'h0000_030C);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL nostall_r0: got %0b expected 0", stall); end
        tick();
    endtask

    task automatic test_flush();
        drive_instr(1'b1, 32'h8C250008, 32'h0000_0400);
        tick();
        drive_instr(1'b1, 32'h00A23020, 32'h0000_0404);
        flush = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_stall: got %0b expected 0", stall); end
        tick();
        n_checks++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_dest !== 5'd0) begin n_fail++; $display("[TB] FAIL flush_bubble: got v=%0b rw=%0b dest=%0d expected 0 0 0", ex_valid, ex_regwrite, ex_dest); end
        flush = 1'b0;
        // ori $9,$1,0x8000 follows normally
        drive_instr(1'b1, 32'h34298000, 32'h0000_0500);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_next_stall: got %0b expected 0", stall); end
        tick();
        n_checks++; if (ex_valid !== 1'b1 || ex_dest !== 5'd9 || ex_imm !== 32'h0000_8000) begin n_fail++; $display("[TB] FAIL flush_next: got v=%0b dest=%0d imm=%h expected 1 9 00008000", ex_valid, ex_dest, ex_imm); end
        // if_id_valid low loads a bubble
        drive_instr(1'b0, 32'h00432020, 32'h0000_0504);
        tick();
        n_checks++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_dest !== 5'd0) begin n_fail++; $display("[TB] FAIL invalid_bubble: got v=%0b rw=%0b dest=%0d expected 0 0 0", ex_valid, ex_regwrite, ex_dest); end
    endtask

    task automatic test_imm_and_decode();
        // andi $8,$1,0xFFFF
        drive_instr(1'b1, 32'h3028FFFF, 32'h0000_0600);
        tick();
        n_checks++; if (ex_imm !== 32'h0000_FFFF || ex_dest !== 5'd8 || ex_alusrc !== 1'b1) begin n_fail++; $display("[TB] FAIL andi: got imm=%h dest=%0d as=%0b expected 0000ffff 8 1", ex_imm, ex_dest, ex_alusrc); end
        // addi $8,$1,-1
        drive_instr(1'b1, 32'h2028FFFF, 32'h0000_0604);
        tick();
        n_checks++; if (ex_imm !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL addi_sext: got %h expected ffffffff", ex_imm); end
        // beq $1,$2,4
        drive_instr(1'b1, 32'h10220004, 32'h0000_0608);
        tick();
        n_checks++; if (ex_branch !== 1'b1 || ex_regwrite !== 1'b0 || ex_dest !== 5'd0 || ex_imm !== 32'd4) begin n_fail++; $display("[TB] FAIL beq: got br=%0b rw=%0b dest=%0d imm=%h expected 1 0 0 4", ex_branch, ex_regwrite, ex_dest, ex_imm); end
        // sw $5,0($1)
        drive_instr(1'b1, 32'hAC250000, 32'h0000_060C);
        tick();
        n_checks++; if (ex_memwrite !== 1'b1 || ex_alusrc !== 1'b1 || ex_dest !== 5'd0 || ex_regwrite !== 1'b0) begin n_fail++; $display("[TB] FAIL sw: got mw=%0b as=%0b dest=%0d rw=%0b expected 1 1 0 0", ex_memwrite, ex_alusrc, ex_dest, ex_regwrite); end
        // unknown opcode 0x3F
        drive_instr(1'b1, 32'hFC221234, 32'h0000_0610);
        tick();
        n_checks++; if ({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch} !== 6'b0 || ex_dest !== 5'd0) begin n_fail++; $display("[TB] FAIL unknown_ctrl: got ctrl=%b dest=%0d expected 000000 0", {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch}, ex_dest); end
        n_checks++; if (ex_valid !== 1'b1 || ex_opcode !== 6'h3F) begin n_fail++; $display("[TB] FAIL unknown_valid: got v=%0b op=%h expected 1 3f", ex_valid, ex_opcode); end
    endtask

    task automatic test_reset_mid_stall();
        drive_instr(1'b1, 32'h8C250008, 32'h0000_0700);
        tick();
        drive_instr(1'b1, 32'h00A23020, 32'h0000_0704);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL rststall_pre: got %0b expected 1", stall); end
        rst = 1'b1;
        tick();
        n_checks++; if (ex_valid !== 1'b0 || ex_memread !== 1'b0 || ex_dest !== 5'd0 || ex_a !== 32'h0) begin n_fail++; $display("[TB] FAIL rststall_clear: got v=%0b mr=%0b dest=%0d a=%h expected 0 0 0 0", ex_valid, ex_memread, ex_dest, ex_a); end
        rst = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL rststall_post: got %0b expected 0", stall); end
        tick();
        n_checks++; if (ex_valid !== 1'b1 || ex_dest !== 5'd6) begin n_fail++; $display("[TB] FAIL rststall_issue: got v=%0b dest=%0d expected 1 6", ex_valid, ex_dest); end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        flush       = 1'b0;
        wb_regwrite = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = 32'h0;
        if_id_valid = 1'b0;
        if_id_instr = 32'h0;
        if_id_pc4   = 32'h0;
        rd_data1    = 32'h0;
        rd_data2    = 32'h0;
        #1;
        test_reset();
        test_rtype();
        test_bypass();
        test_load_use();
        test_no_stall();
        test_flush();
        test_imm_and_decode();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
